// File: rtl/sub_pkg.sv
// sub_pkg: shared widths and flag bundle for the pipelined subtractor
package sub_pkg;
  localparam int WIDTH = 32;
  localparam int SLICE_W = 4;
  localparam int HALF_W = WIDTH / 2;
  typedef struct packed {
    logic borrow;
    logic ovf;
    logic zero;
    logic lt_s;
  } flags_t;
endpackage

// File: rtl/sub4_cla.sv
// sub4_cla: 4-bit carry-lookahead slice computing x + y + cin; y arrives already inverted
module sub4_cla (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       c4
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = x & y;
  assign p = x ^ y;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & c[0]);
  assign sum = p ^ c[3:0];
  assign c3 = c[3];
  assign c4 = c[4];
endmodule

// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage a - b (a + ~b + 1) with low half in stage 1, high half and flags in stage 2
module sub32_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = sub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_lt_s
);
  localparam int H = WIDTH / 2;
  localparam int N = H / SLICE_W;
  logic s1_valid, s2_valid, s1_adv, s1_c;
  logic [H-1:0] s1_lo, s1_a_hi, s1_nb_hi, lo_sum, hi_sum, nb_lo;
  logic [N:0] lc, hc;
  logic [N-1:0] hc3;
  logic [WIDTH-1:0] diff;
  flags_t flags;
  assign s1_adv = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign nb_lo = ~in_b[H-1:0];
  assign lc[0] = 1'b1;
  assign hc[0] = s1_c;
  for (genvar i = 0; i < N; i++) begin : g_slices
    sub4_cla u_lo (.x(in_a[i*SLICE_W +: SLICE_W]), .y(nb_lo[i*SLICE_W +: SLICE_W]), .cin(lc[i]),
                   .sum(lo_sum[i*SLICE_W +: SLICE_W]), .c3(), .c4(lc[i+1]));
    sub4_cla u_hi (.x(s1_a_hi[i*SLICE_W +: SLICE_W]), .y(s1_nb_hi[i*SLICE_W +: SLICE_W]), .cin(hc[i]),
                   .sum(hi_sum[i*SLICE_W +: SLICE_W]), .c3(hc3[i]), .c4(hc[i+1]));
  end
  assign diff = {hi_sum, s1_lo};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_nb_hi <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo    <= lo_sum;
        s1_c     <= lc[N];
        s1_a_hi  <= in_a[WIDTH-1:H];
        s1_nb_hi <= ~in_b[WIDTH-1:H];
      end
    end
  end
  // borrow is the inverted final carry; ovf compares carries into and out of the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_diff <= '0;
      flags    <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_diff     <= diff;
        flags.borrow <= ~hc[N];
        flags.ovf    <= hc3[N-1] ^ hc[N];
        flags.zero   <= ~|diff;
        flags.lt_s   <= diff[WIDTH-1] ^ (hc3[N-1] ^ hc[N]);
      end
    end
  end
  assign out_valid = s2_valid;
  assign out_borrow = flags.borrow;
  assign out_ovf = flags.ovf;
  assign out_zero = flags.zero;
  assign out_lt_s = flags.lt_s;
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: directed vector table, streaming scoreboard and async reset checks for sub32_pipe
module tb_sub32_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_borrow, out_ovf, out_zero, out_lt_s;
  logic [31:0] in_a = 0, in_b = 0, out_diff;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] a, b, diff;
    logic borrow, ovf, zero, lt_s;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  sub32_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_lt_s(out_lt_s)
  );

  function automatic logic [35:0] ref_res(logic [31:0] a, logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return {d, a < b, (a[31] != b[31]) && (d[31] != a[31]), a == b, $signed(a) < $signed(b)};
  endfunction

  function automatic logic [35:0] dut_res();
    return {out_diff, out_borrow, out_ovf, out_zero, out_lt_s};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp, input string name);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1; out_ready = 1;
    #1 check({name, " in_ready"}, 40'(in_ready), 40'd1);
    @(negedge clk);
    in_valid = 0;
    check({name, " early"}, 40'(out_valid), 40'd0);
    @(negedge clk);
    check({name, " valid"}, 40'(out_valid), 40'd1);
    check(name, 40'(dut_res()), 40'(exp));
  endtask

  task automatic stream(input int nops, input bit patterned);
    logic [35:0] q[$];
    bit pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    int sent = 0, got = 0, k = 0, cyc = 0;
    bit stalled = 0;
    logic [36:0] held = '0;
    while (got < nops && cyc < 2000) begin
      @(negedge clk);
      if (stalled) check("hold", 40'({out_valid, dut_res()}), 40'(held));
      out_ready = patterned ? pat[cyc % 8] : 1'($urandom_range(0, 1));
      in_valid = (sent < nops) && (patterned || $urandom_range(0, 3) != 0);
      in_a = $urandom;
      in_b = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
      cyc++;
      #1 check("in_ready", 40'(in_ready), 40'((k < 2) || out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious", 40'd1, 40'd0);
        else check("order", 40'(dut_res()), 40'(q.pop_front()));
        got++; k--;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_res(in_a, in_b));
        sent++; k++;
      end
      stalled = out_valid && !out_ready;
      held = {out_valid, dut_res()};
    end
    check("stream done", 40'(got), 40'(nops));
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    vecs[0] = '{32'd5, 32'd3, 32'h00000002, 0, 0, 0, 0};
    vecs[1] = '{32'd3, 32'd5, 32'hFFFFFFFE, 1, 0, 0, 1};
    vecs[2] = '{32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0, 1};
    vecs[3] = '{32'h0000FFFF, 32'hFFFF0000, 32'h0001FFFF, 1, 0, 0, 0};
    vecs[4] = '{32'h00001234, 32'h00001234, 32'h00000000, 0, 0, 1, 0};
    vecs[5] = '{32'd0, 32'd0, 32'h00000000, 0, 0, 1, 0};
    vecs[6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 1, 0, 0, 1};
    vecs[7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0, 0};
    #1 check("reset outputs", 40'({out_valid, dut_res()}), 40'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++)
      single(vecs[i].a, vecs[i].b, {vecs[i].diff, vecs[i].borrow, vecs[i].ovf, vecs[i].zero, vecs[i].lt_s},
             $sformatf("vec%0d", i));
    stream(8, 1);
    stream(200, 0);
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_a = 32'd100; in_b = 32'd1;
    @(negedge clk);
    in_a = 32'd200; in_b = 32'd2;
    @(negedge clk);
    in_valid = 0;
    check("two in flight", 40'({out_valid, in_ready}), 40'b10);
    #2 rst_n = 0;
    #1 check("async reset", 40'({out_valid, dut_res()}), 40'd0);
    @(negedge clk);
    rst_n = 1;
    #1 check("ready after reset", 40'({in_ready, out_valid}), 40'b10);
    single(32'd9, 32'd4, ref_res(32'd9, 32'd4), "post reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
